// File: rtl/spi_slave_regif.sv
// SPI responder that turns SPI frames into fabric register accesses.
// The first word of a frame is a command (MSB = read, low bits = start address);
// every following word is one register write or one register read, with the
// address auto-incrementing (wrapping) inside the frame.
module spi_slave_regif #(
    parameter int CLK_FREQUENCE = 50_000_000,
    parameter int SPI_FREQUENCE = 5_000_000,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 7,
    parameter bit CPOL          = 1'b0,
    parameter bit CPHA          = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  reg_wr,
    output logic                  reg_rd,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CLK_PER_SCLK = CLK_FREQUENCE / SPI_FREQUENCE;
    localparam int CNT_W        = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    // The synchronizer plus edge detect costs ~3 clk per sclk edge; half an sclk period must cover it.
    generate
        if (CLK_PER_SCLK < 8) begin : g_ratio_check
            $error("spi_slave_regif: CLK_FREQUENCE/SPI_FREQUENCE must be >= 8");
        end
        if (ADDR_WIDTH > DATA_WIDTH - 1) begin : g_addr_check
            $error("spi_slave_regif: ADDR_WIDTH must be <= DATA_WIDTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    // Two-stage synchronizers for the asynchronous pins, plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        sclk_meta_q <= sclk;
        sclk_sync_q <= sclk_meta_q;
        sclk_prev_q <= sclk_sync_q;
        cs_meta_q   <= cs_n;
        cs_sync_q   <= cs_meta_q;
        cs_prev_q   <= cs_sync_q;
        mosi_meta_q <= mosi;
        mosi_sync_q <= mosi_meta_q;
    end

    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;

    assign lead_edge   = (sclk_prev_q == CPOL) && (sclk_sync_q != CPOL);
    assign trail_edge  = (sclk_prev_q != CPOL) && (sclk_sync_q == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_q && !cs_sync_q;
    assign cs_rise     = !cs_prev_q && cs_sync_q;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  miso_q, miso_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic                  cap_q, cap_d;
    logic                  busy_q, busy_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] word;

    // Frame sequencing: bit counting, command decode, strobe generation and read-data shifting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        miso_d  = miso_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        cap_d   = rd_q;
        busy_d  = !cs_sync_q;
        ferr_d  = 1'b0;
        word    = {rx_q[DATA_WIDTH-2:0], mosi_sync_q};

        // A write strobe has just gone out at addr_q; step to the next register.
        if (reg_wr) begin
            addr_d = addr_q + 1'b1;
        end

        if (state_q == S_RDATA && shift_edge) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end

        // Fabric answers one clk after reg_rd; the load lands well before the next shift edge.
        if (cap_q) begin
            tx_d = reg_rdata;
        end

        if (state_q == S_IDLE) begin
            if (cs_fall) begin
                state_d = S_CMD;
                cnt_d   = '0;
                tx_d    = '0;
                miso_d  = 1'b0;
            end
        end else begin
            if (sample_edge) begin
                rx_d = word;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d = '0;
                    case (state_q)
                        S_CMD: begin
                            addr_d = word[ADDR_WIDTH-1:0];
                            if (word[DATA_WIDTH-1]) begin
                                state_d = S_RDATA;
                                rd_d    = 1'b1;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                        S_WDATA: begin
                            wr_d    = 1'b1;
                            wdata_d = word;
                        end
                        default: begin
                            // Prefetch the next register so the following word streams without a gap.
                            addr_d = addr_q + 1'b1;
                            rd_d   = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A word completing in this same clk has already issued its strobe above.
            if (cs_rise) begin
                state_d = S_IDLE;
                miso_d  = 1'b0;
                ferr_d  = (cnt_d != '0);
                cnt_d   = '0;
            end
        end
    end

    // Control and output registers, returned to their idle values by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            miso_q  <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cap_q   <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            miso_q  <= miso_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cap_q   <= cap_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
        end
    end

    // Shift registers carry data only; they are cleared or reloaded at frame start.
    always_ff @(posedge clk) begin
        rx_q <= rx_d;
        tx_q <= tx_d;
    end

    assign miso      = miso_q;
    assign reg_wr    = wr_q;
    assign reg_rd    = rd_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: one instance per SPI mode, a bit-level SPI master,
// a fabric that answers reads with addr+0x30, and a frame-level reference model.
module tb_spi_slave_regif;

    logic       clk;
    logic       rst;
    logic       sclk_a  [4];
    logic       cs_a    [4];
    logic       mosi_a  [4];
    logic       miso_a  [4];
    logic       wr_a    [4];
    logic       rd_a    [4];
    logic [6:0] addr_a  [4];
    logic [7:0] wdata_a [4];
    logic       busy_a  [4];
    logic       ferr_a  [4];

    int checks = 0;
    int passed = 0;
    int cur    = 0;

    logic [14:0] wr_log[$];
    logic [6:0]  rd_log[$];
    int          both_cnt;
    int          ferr_cnt;

    typedef struct {
        int              mode;
        int              half;
        int              nw;
        logic [3:0][7:0] w;
        int              lb;
        int              exp_n;
        logic [6:0]      exp_a0;
        logic [7:0]      exp_v0;
    } vec_t;

    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [7:0] fab_q;
        always @(posedge clk) if (rd_a[g]) fab_q <= {1'b0, addr_a[g]} + 8'h30;

        spi_slave_regif #(
            .CLK_FREQUENCE(50_000_000),
            .SPI_FREQUENCE(5_000_000),
            .DATA_WIDTH   (8),
            .ADDR_WIDTH   (7),
            .CPOL         (g >= 2),
            .CPHA         (g % 2 == 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .sclk     (sclk_a[g]),
            .cs_n     (cs_a[g]),
            .mosi     (mosi_a[g]),
            .miso     (miso_a[g]),
            .reg_wr   (wr_a[g]),
            .reg_rd   (rd_a[g]),
            .reg_addr (addr_a[g]),
            .reg_wdata(wdata_a[g]),
            .reg_rdata(fab_q),
            .busy     (busy_a[g]),
            .frame_err(ferr_a[g])
        );
    end

    // Strobe monitor for the instance currently under test
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_a[cur]) wr_log.push_back({addr_a[cur], wdata_a[cur]});
            if (rd_a[cur]) rd_log.push_back(addr_a[cur]);
            if (wr_a[cur] && rd_a[cur]) both_cnt++;
            if (ferr_a[cur]) ferr_cnt++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input int m, input int half, input logic [7:0] wd, input int nb,
                             output logic [7:0] rxw);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        rxw  = '0;
        for (int b = 7; b > 7 - nb; b--) begin
            if (!cpha) begin
                mosi_a[m] = wd[b];
                wait_clk(half);
                rxw = {rxw[6:0], miso_a[m]};
                sclk_a[m] = ~cpol;
                wait_clk(half);
                sclk_a[m] = cpol;
            end else begin
                sclk_a[m] = ~cpol;
                mosi_a[m] = wd[b];
                wait_clk(half);
                rxw = {rxw[6:0], miso_a[m]};
                sclk_a[m] = cpol;
                wait_clk(half);
            end
        end
    endtask

    task automatic clear_logs(input int m);
        cur = m;
        wr_log.delete();
        rd_log.delete();
        both_cnt = 0;
        ferr_cnt = 0;
    endtask

    task automatic run_frame(input vec_t v, output logic [3:0][7:0] rx);
        logic [7:0] r;
        clear_logs(v.mode);
        rx = '0;
        cs_a[v.mode] = 1'b0;
        wait_clk(v.half);
        for (int i = 0; i < v.nw; i++) begin
            send_bits(v.mode, v.half, v.w[i], (i == v.nw - 1) ? v.lb : 8, r);
            rx[i] = r;
        end
        wait_clk(v.half);
        cs_a[v.mode] = 1'b1;
        wait_clk(4 * v.half + 8);
    endtask

    // Frame-level reference: expected strobes and read data follow from the command word alone
    task automatic check_frame(input vec_t v, input logic [3:0][7:0] rx, input bit directed);
        logic       rd;
        logic [6:0] a;
        int         nfull;
        rd    = v.w[0][7];
        a     = v.w[0][6:0];
        nfull = (v.lb == 8) ? v.nw : v.nw - 1;
        if (!rd) begin
            check("wr_count", wr_log.size(), nfull - 1);
            for (int i = 1; i < nfull && i - 1 < wr_log.size(); i++)
                check("wr_entry", wr_log[i-1], {7'(a + i - 1), v.w[i]});
            check("rd_count_on_write", rd_log.size(), 0);
            for (int i = 0; i < nfull; i++)
                check("miso_idle_on_write", rx[i], 0);
        end else begin
            check("rd_count", rd_log.size(), nfull);
            for (int k = 0; k < nfull && k < rd_log.size(); k++)
                check("rd_addr", rd_log[k], 7'(a + k));
            check("miso_during_cmd", rx[0], 0);
            for (int i = 1; i < nfull; i++)
                check("miso_read_word", rx[i], 8'({1'b0, 7'(a + i - 1)} + 8'h30));
            check("wr_count_on_read", wr_log.size(), 0);
        end
        check("frame_err_count", ferr_cnt, (v.lb != 8) ? 1 : 0);
        check("wr_rd_overlap", both_cnt, 0);
        check("busy_after_frame", busy_a[v.mode], 0);
        if (directed) begin
            check("dir_strobes", rd ? rd_log.size() : wr_log.size(), v.exp_n);
            if (v.exp_n > 0) begin
                if (!rd && wr_log.size() > 0) begin
                    check("dir_first_addr", wr_log[0][14:8], v.exp_a0);
                    check("dir_first_data", wr_log[0][7:0], v.exp_v0);
                end else if (rd && rd_log.size() > 0) begin
                    check("dir_first_addr", rd_log[0], v.exp_a0);
                    check("dir_first_data", rx[1], v.exp_v0);
                end
            end
        end
    endtask

    initial begin
        vec_t            v;
        logic [3:0][7:0] rx;
        logic [7:0]      r;

        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            sclk_a[g] = (g >= 2);
            cs_a[g]   = 1'b1;
            mosi_a[g] = 1'b0;
        end

        // Directed table: single write and read frames in every mode at two clock ratios
        for (int m = 0; m < 4; m++) begin
            for (int h = 4; h <= 5; h++) begin
                tbl.push_back('{mode: m, half: h, nw: 2, w: {8'h00, 8'h00, 8'hA5, 8'h05}, lb: 8,
                                exp_n: 1, exp_a0: 7'h05, exp_v0: 8'hA5});
                tbl.push_back('{mode: m, half: h, nw: 3, w: {8'h00, 8'h00, 8'h00, 8'h83}, lb: 8,
                                exp_n: 3, exp_a0: 7'h03, exp_v0: 8'h33});
            end
        end
        tbl.push_back('{mode: 0, half: 4, nw: 4, w: {8'h33, 8'h22, 8'h11, 8'h7E}, lb: 8,
                        exp_n: 3, exp_a0: 7'h7E, exp_v0: 8'h11});
        tbl.push_back('{mode: 0, half: 4, nw: 2, w: {8'h00, 8'h00, 8'h55, 8'h10}, lb: 5,
                        exp_n: 0, exp_a0: 7'h00, exp_v0: 8'h00});
        tbl.push_back('{mode: 3, half: 5, nw: 3, w: {8'h00, 8'h00, 8'h00, 8'hFF}, lb: 8,
                        exp_n: 3, exp_a0: 7'h7F, exp_v0: 8'hAF});

        wait_clk(6);
        for (int g = 0; g < 4; g++) begin
            check("rst_miso", miso_a[g], 0);
            check("rst_reg_wr", wr_a[g], 0);
            check("rst_reg_rd", rd_a[g], 0);
            check("rst_reg_addr", addr_a[g], 0);
            check("rst_reg_wdata", wdata_a[g], 0);
            check("rst_busy", busy_a[g], 0);
            check("rst_frame_err", ferr_a[g], 0);
        end
        rst = 1'b0;
        wait_clk(4);

        foreach (tbl[i]) begin
            run_frame(tbl[i], rx);
            check_frame(tbl[i], rx, 1'b1);
        end

        // rst in the middle of a write data word, then a fresh frame
        clear_logs(0);
        cs_a[0] = 1'b0;
        wait_clk(4);
        send_bits(0, 4, 8'h20, 8, r);
        send_bits(0, 4, 8'h77, 3, r);
        rst = 1'b1;
        wait_clk(2);
        check("midrst_addr", addr_a[0], 0);
        check("midrst_wr", wr_a[0], 0);
        rst = 1'b0;
        send_bits(0, 4, 8'hFF, 5, r);
        wait_clk(4);
        cs_a[0] = 1'b1;
        wait_clk(30);
        check("midrst_no_wr", wr_log.size(), 0);
        check("midrst_no_ferr", ferr_cnt, 0);
        v = '{mode: 0, half: 4, nw: 2, w: {8'h00, 8'h00, 8'h5A, 8'h01}, lb: 8,
              exp_n: 1, exp_a0: 7'h01, exp_v0: 8'h5A};
        run_frame(v, rx);
        check_frame(v, rx, 1'b1);

        // Randomized frames against the reference model
        for (int n = 0; n < 16; n++) begin
            v.mode = $urandom_range(0, 3);
            v.half = $urandom_range(4, 5);
            v.nw   = $urandom_range(2, 4);
            for (int i = 0; i < 4; i++) v.w[i] = 8'($urandom);
            v.lb    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            v.exp_n = 0;
            run_frame(v, rx);
            check_frame(v, rx, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
